// File: rtl/line_window_gen_pkg.sv
// ============================================================================
// line_window_gen_pkg
// Shared types and constants for the 3x3 line-window generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package line_window_gen_pkg;

  // Frame-level control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Window tap indices, row-major, W0 = oldest row/column, W8 = newest pixel
  localparam int W0 = 0;
  localparam int W1 = 1;
  localparam int W2 = 2;
  localparam int W3 = 3;
  localparam int W4 = 4;
  localparam int W5 = 5;
  localparam int W6 = 6;
  localparam int W7 = 7;
  localparam int W8 = 8;

  localparam int NTAPS = 9;

  // Smallest frame dimension that still yields at least one full window
  localparam int MIN_DIM = 3;

endpackage

`default_nettype wire

// File: rtl/lwg_line_buf.sv
// ============================================================================
// lwg_line_buf
// One-line pixel store: one read and one write per cycle at the same address.
// The read returns the old contents (read-before-write). No reset on storage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lwg_line_buf #(
  parameter  int DW   = 8,
  parameter  int MAXW = 256,
  localparam int AW   = (MAXW > 1) ? $clog2(MAXW) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [MAXW];

  // Asynchronous read of the current entry; the write below lands at the
  // clock edge, so the same-cycle read always sees the previous line's pixel.
  assign rdata = mem[addr];

  // Write the new pixel for this column
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_window_gen.sv
// ============================================================================
// line_window_gen
// Streams a raster frame through two line buffers and emits every fully
// interior 3x3 neighbourhood with a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int DW   = 8,
  parameter int MAXW = 256,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   img_w,
  input  logic [CW-1:0]   img_h,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9*DW-1:0] win,
  output logic [CW-1:0]   out_row,
  output logic [CW-1:0]   out_col,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;

  // Comparison constants sized one bit wider than the dimension ports so
  // that MAXW == 2^CW is still representable.
  localparam logic [CW:0]   MAXW_C = (CW+1)'(MAXW);
  localparam logic [CW:0]   MINW_C = (CW+1)'(MIN_DIM);
  localparam logic [CW-1:0] MINH_C = CW'(MIN_DIM);
  localparam logic [CW-1:0] TWO_C  = CW'(2);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t        state;
  state_t        state_nx;

  logic [CW-1:0] w_lat;
  logic [CW-1:0] h_lat;
  logic [CW-1:0] row;
  logic [CW-1:0] col;

  logic [DW-1:0] wr [NTAPS];
  logic [DW-1:0] lb1_rd;
  logic [DW-1:0] lb2_rd;
  logic [AW-1:0] lb_addr;

  logic          dims_ok;
  logic          launch;
  logic          accept;
  logic          at_col_end;
  logic          at_row_end;
  logic          emit;

  // --------------------------------------------------------------------------
  // Decode helpers
  // --------------------------------------------------------------------------
  assign dims_ok    = ({1'b0, img_w} >= MINW_C) && ({1'b0, img_w} <= MAXW_C)
                   && (img_h >= MINH_C);
  assign launch     = (state == ST_IDLE) && start && dims_ok;
  assign accept     = in_valid && in_ready;
  assign at_col_end = (col == (w_lat - ONE_C));
  assign at_row_end = (row == (h_lat - ONE_C));
  // Only windows whose left two columns belong to the same line and whose
  // top row exists in this frame are published.
  assign emit       = accept && (row >= TWO_C) && (col >= TWO_C);
  assign lb_addr    = col[AW-1:0];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nx = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        // The last window can only be produced by the final accept, so its
        // handshake marks frame completion.
        if (out_valid && out_ready && out_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Rejected start pulses err for one cycle; start outside IDLE is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) && start && !dims_ok;
    end
  end

  // --------------------------------------------------------------------------
  // Frame geometry and raster position
  // --------------------------------------------------------------------------

  // Latch dimensions on launch and advance the raster position on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_lat <= '0;
      h_lat <= '0;
      row   <= '0;
      col   <= '0;
    end else if (launch) begin
      w_lat <= img_w;
      h_lat <= img_h;
      row   <= '0;
      col   <= '0;
    end else if (accept) begin
      if (at_col_end) begin
        col <= '0;
        row <= at_row_end ? '0 : (row + ONE_C);
      end else begin
        col <= col + ONE_C;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 at each column
  // --------------------------------------------------------------------------
  lwg_line_buf #(
    .DW   (DW),
    .MAXW (MAXW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (lb_addr),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  lwg_line_buf #(
    .DW   (DW),
    .MAXW (MAXW)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (lb_addr),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  // --------------------------------------------------------------------------
  // Window shift register
  // --------------------------------------------------------------------------

  // Shift left one column per accepted pixel and load the new column.
  // Shifting is tied to accept, and accept is blocked while a window is
  // stalled, so the published payload stays stable until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        wr[i] <= '0;
      end
    end else if (accept) begin
      wr[W0] <= wr[W1];
      wr[W1] <= wr[W2];
      wr[W2] <= lb2_rd;
      wr[W3] <= wr[W4];
      wr[W4] <= wr[W5];
      wr[W5] <= lb1_rd;
      wr[W6] <= wr[W7];
      wr[W7] <= wr[W8];
      wr[W8] <= in_pixel;
    end
  end

  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_win
      assign win[gi*DW +: DW] = wr[gi];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output handshake and centre coordinates
  // --------------------------------------------------------------------------

  // A new window replaces the current one with no bubble; otherwise the
  // current one is retired when downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= at_row_end && at_col_end;
      out_row   <= row - ONE_C;
      out_col   <= col - ONE_C;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_window_gen.sv
// ============================================================================
// tb_line_window_gen
// Directed and soak bench for line_window_gen; expected windows are rebuilt
// from the pixel generator formula at each reported centre coordinate.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_line_window_gen;

  localparam int DW   = 8;
  localparam int MAXW = 16;
  localparam int CW   = 8;

  logic            clk       = 1'b0;
  logic            rst       = 1'b0;
  logic            start     = 1'b0;
  logic [CW-1:0]   img_w     = '0;
  logic [CW-1:0]   img_h     = '0;
  logic            in_valid  = 1'b0;
  logic [DW-1:0]   in_pixel  = '0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [9*DW-1:0] win;
  logic [CW-1:0]   out_row;
  logic [CW-1:0]   out_col;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  // Current frame description, shared with the monitor
  int cur_w = 4;
  int cur_h = 4;
  int cur_seed = 0;
  bit mon_on = 1'b0;

  // Monitor statistics for the current frame
  int ncyc = 0;
  int nwin = 0;
  int ndone = 0;
  int last_hs = -1;
  int done_cyc = -1;
  bit have_first = 1'b0;
  logic [9*DW-1:0] first_win = '0;
  logic [CW-1:0]   first_row = '0;
  logic [CW-1:0]   first_col = '0;

  bit              prev_v = 1'b0;
  bit              prev_r = 1'b0;
  logic [9*DW-1:0] prev_win = '0;
  logic [2*CW-1:0] prev_rc = '0;

  always #5 clk = ~clk;

  line_window_gen #(
    .DW   (DW),
    .MAXW (MAXW),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win       (win),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pixel value at raster position (r,c) of the current frame
  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * cur_w + c + cur_seed);
  endfunction

  // Reference 3x3 window centred on (r,c), w0 at LSBs
  function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
    logic [9*DW-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      v[i*DW +: DW] = pix(r - 1 + i / 3, c - 1 + i % 3);
    end
    return v;
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    ncyc++;
    if (mon_on && rst) begin
      if (prev_v && !prev_r) begin
        check("hold_valid", out_valid, 1);
        check("hold_win", win, prev_win);
        check("hold_rowcol", {out_row, out_col}, prev_rc);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        nwin++;
        check("win_data", win, exp_win(int'(out_row), int'(out_col)));
        check("out_last", out_last,
              (int'(out_row) == cur_h - 2) && (int'(out_col) == cur_w - 2));
        if (!have_first) begin
          have_first = 1'b1;
          first_win  = win;
          first_row  = out_row;
          first_col  = out_col;
        end
        if (out_last) last_hs = ncyc;
      end
      if (done) begin
        ndone++;
        done_cyc = ncyc;
      end
    end
    prev_v   = mon_on && rst && out_valid;
    prev_r   = out_ready;
    prev_win = win;
    prev_rc  = {out_row, out_col};
  end

  task automatic start_frame(input int w, input int h, input int seed);
    cur_w = w; cur_h = h; cur_seed = seed;
    nwin = 0; ndone = 0; last_hs = -1; done_cyc = -1; have_first = 1'b0;
    img_w = CW'(w);
    img_h = CW'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // mode 0: always ready; mode 1: out_ready 1,0,0,1; mode 2: random stalls
  task automatic stream(input int mode, input int limit);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < limit && cyc < 4000) begin
      in_pixel = pix(idx / cur_w, idx % cur_w);
      case (mode)
        0: begin in_valid = 1'b1; out_ready = 1'b1; end
        1: begin in_valid = 1'b1; out_ready = (cyc % 4 == 0) || (cyc % 4 == 3); end
        default: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 2) != 0);
        end
      endcase
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_accepts", idx, limit);
  endtask

  task automatic finish_frame(input int mode);
    int cyc = 0;
    while (ndone == 0 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", ndone, 1);
    check("win_count", nwin, (cur_w - 2) * (cur_h - 2));
    check("done_timing", done_cyc, last_hs + 1);
    check("idle_after_done", busy, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int bad_w [3] = '{2, MAXW + 1, 4};
    int bad_h [3] = '{4, 4, 2};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_win", win, 0);
    check("rst_row_col", {out_row, out_col}, 0);
    check("rst_last", out_last, 0);
    rst = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Illegal dimensions are rejected with a single err pulse
    for (int k = 0; k < 3; k++) begin
      img_w = CW'(bad_w[k]);
      img_h = CW'(bad_h[k]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("bad_err_pulse", err, 1);
      check("bad_busy", busy, 0);
      check("bad_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("bad_err_clear", err, 0);
      check("bad_stay_idle", busy, 0);
    end

    // 4x4 frame of 0..15, with an ignored start while active
    start_frame(4, 4, 0);
    img_w = CW'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("active_start_no_err", err, 0);
    check("active_start_busy", busy, 1);
    stream(0, 16);
    finish_frame(0);
    check("first_win_4x4", first_win, 72'h0A_09_08_06_05_04_02_01_00);
    check("first_row_4x4", first_row, 1);
    check("first_col_4x4", first_col, 1);

    // 5x3 frame with out_ready pattern 1,0,0,1
    start_frame(5, 3, 11);
    stream(1, 15);
    finish_frame(1);

    // Two back-to-back full-width frames
    start_frame(MAXW, 3, 5);
    stream(0, MAXW * 3);
    finish_frame(0);
    start_frame(MAXW, 3, 77);
    stream(0, MAXW * 3);
    finish_frame(0);

    // Asynchronous reset mid-frame, then a fresh 3x3 frame
    start_frame(4, 4, 0);
    stream(0, 7);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_win", win, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_frame(3, 3, 0);
    stream(0, 9);
    finish_frame(0);
    check("post_rst_win", first_win, 72'h08_07_06_05_04_03_02_01_00);

    // Random-stall soak over legal frames
    for (int f = 0; f < 100; f++) begin
      int w;
      int h;
      w = $urandom_range(3, MAXW);
      h = $urandom_range(3, 6);
      start_frame(w, h, $urandom_range(0, 255));
      stream(2, w * h);
      finish_frame(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter MAXW, default 256, meaning maximum line width in pixels and line-buffer depth.
REQ-003 The block SHALL have parameter CW, default 8, meaning width of the dimension and coordinate fields (2^CW >= MAXW).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, a frame-start pulse that latches img_w and img_h.
REQ-007 The block SHALL have port img_w, input, CW, the frame width in pixels.
REQ-008 The block SHALL have port img_h, input, CW, the frame height in lines.
REQ-009 The block SHALL have port in_valid, input, 1, marking in_pixel as valid.
REQ-010 The block SHALL have port in_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-011 The block SHALL have port in_pixel, input, DW, the raster-order pixel.
REQ-012 The block SHALL have port out_valid, output, 1, marking the window as valid.
REQ-013 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-014 The block SHALL have port win, output, 9*DW, the 3x3 window, row-major, w0 at LSBs = (r-2,c-2), w8 = (r,c).
REQ-015 The block SHALL have port out_row, output, CW, the row of the centre pixel w4.
REQ-016 The block SHALL have port out_col, output, CW, the column of the centre pixel w4.
REQ-017 The block SHALL have port out_last, output, 1, flagging the final window of the frame.
REQ-018 The block SHALL have port busy, output, 1, high while state is ACTIVE.
REQ-019 The block SHALL have port done, output, 1, a one-cycle pulse at frame completion.
REQ-020 The block SHALL have port err, output, 1, a one-cycle pulse when start is rejected.

Function
REQ-021 FSM SHALL have states IDLE, ACTIVE, DONE.
REQ-022 In IDLE, start with 3<=img_w<=MAXW and 3<=img_h SHALL latch the dimensions, clear the row/col counters and go to ACTIVE next cycle.
REQ-023 In IDLE, start with illegal dimensions SHALL pulse err the next cycle and stay in IDLE.
REQ-024 start while ACTIVE or DONE SHALL be ignored; no err pulse.
REQ-025 in_ready SHALL equal (state==ACTIVE) && (!out_valid || out_ready); it is combinational from the registered state.
REQ-026 A pixel SHALL be accepted only on in_valid && in_ready; no other cycle alters the counters, line buffers or window.
REQ-027 On accept at (r,c): read lb1[c] and lb2[c]; write lb2[c]<=lb1[c] and lb1[c]<=in_pixel; shift the window left one column; load the new column as {lb2[c], lb1[c], in_pixel}.
REQ-028 Line buffers SHALL be two single-port-per-cycle arrays of MAXW x DW, addressed by column; their contents are unaffected by reset.
REQ-029 Column SHALL wrap at img_w-1 to 0 and increment row; the accept at (img_h-1, img_w-1) ends the frame.
REQ-030 out_valid SHALL be registered, set one cycle after an accept with r>=2 and c>=2, and carry out_row=r-1 and out_col=c-1.
REQ-031 Windows straddling a line wrap (c<2) SHALL never be emitted; the count of windows per frame is exactly (img_w-2)*(img_h-2).
REQ-032 out_valid and its payload SHALL hold stable until out_ready; out_valid is cleared on out_ready unless a new window is loaded in the same cycle.
REQ-033 Simultaneous out_ready and accept SHALL replace the window with no bubble, giving throughput of one pixel per clock.
REQ-034 out_last SHALL be high together with the window for (img_h-2, img_w-2).
REQ-035 After the final accept, the FSM SHALL go to DONE once the last window handshakes; done pulses for one cycle; then back to IDLE.

Reset
REQ-036 Asserted rst SHALL immediately force state IDLE, clear the counters, set out_valid, out_last, busy, done, err to 0 and win, out_row, out_col to 0.
REQ-037 Reset mid-frame SHALL abandon the frame; the next frame requires a new start, and stale line-buffer data never appears in a window because r>=2 gating applies.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the window index constants W0..W8, and the minimum dimension constant 3.
REQ-039 One sub-module, lwg_line_buf (parametrised DW, MAXW; one read and one write per cycle, same address, read-before-write), SHALL be instantiated twice.

Verification
REQ-040 Reset then start with img_w=4, img_h=4 and pixels 0..15 streamed with out_ready=1 SHALL produce 4 windows, the first being win={0,1,2,4,5,6,8,9,10} with out_row=1 and out_col=1, out_last on (2,2), and done one cycle after.
REQ-041 start with img_w=2 or img_w=MAXW+1 SHALL pulse err, keep in_ready=0 and leave state IDLE.
REQ-042 A 5x3 frame with out_ready toggled 1,0,0,1 SHALL deliver exactly 3 windows with payload held stable during stalls and in_ready=0 while stalled with out_valid=1.
REQ-043 Two back-to-back MAXW x 3 frames SHALL both produce MAXW-2 correct windows, showing line-buffer reuse at full depth.
REQ-044 rst asserted after 7 accepts of a 4x4 frame SHALL drop out_valid and busy asynchronously; a new 3x3 frame SHALL then yield exactly 1 window, equal to pixels 0..8.
REQ-045 A random-stall soak over 100 random legal frames SHALL match a reference model window-for-window, with window count per frame equal to (img_w-2)*(img_h-2).
